// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences a shared datapath through IF/ID/EX/MEM/WB
// over a single req/ack memory port, counts retired instructions and flags illegal ones.
module multicycle_ctrl #(
  parameter int CNT_W        = 16,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWr,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             RegWr,
  output logic             RegDst,
  output logic             AluSrc,
  output logic             ExtOp,
  output logic             MemtoReg,
  output logic [2:0]       Aluctr,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic       legal, is_r, is_ori, is_addiu, is_lw, is_sw, is_beq, is_j;
  logic [2:0] alu_sel;

  // Instruction decode; only meaningful once IR is loaded (ID onward).
  always_comb begin
    legal    = 1'b0;
    alu_sel  = 3'b000;
    is_r     = (op == OP_RTYPE);
    is_ori   = (op == OP_ORI);
    is_addiu = (op == OP_ADDIU);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (func)
          F_ADD:   alu_sel = 3'b001;
          F_SUB:   alu_sel = 3'b101;
          F_SUBU:  alu_sel = 3'b100;
          F_SLT:   alu_sel = 3'b111;
          F_SLTU:  alu_sel = 3'b110;
          default: legal   = 1'b0;
        endcase
      end
      OP_ORI:                begin legal = 1'b1; alu_sel = 3'b010; end
      OP_ADDIU, OP_LW, OP_SW: begin legal = 1'b1; alu_sel = 3'b000; end
      OP_BEQ:                begin legal = 1'b1; alu_sel = 3'b100; end
      OP_J:                  legal = 1'b1;
      default:               legal = 1'b0;
    endcase
  end

  // Outputs are forced low while rst is held so mem_req/mem_we drop without a clock.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCSrc    = 2'b00;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    ExtOp    = 1'b0;
    MemtoReg = 1'b0;
    Aluctr   = 3'b000;
    retire   = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IF: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            state_d = ST_ID;
          end
        end
        ST_ID: begin
          if (is_j) begin
            PCWr    = 1'b1;
            PCSrc   = 2'b10;
            retire  = 1'b1;
            state_d = ST_IF;
          end else if (legal) begin
            state_d = ST_EX;
          end else begin
            illegal = 1'b1;
            state_d = ILLEGAL_HALT ? ST_HALT : ST_IF;
          end
        end
        ST_EX: begin
          Aluctr = alu_sel;
          RegDst = is_r;
          AluSrc = is_ori | is_addiu | is_lw | is_sw;
          ExtOp  = is_addiu | is_lw | is_sw;
          if (is_beq) begin
            PCWr    = zero;
            PCSrc   = 2'b01;
            retire  = 1'b1;
            state_d = ST_IF;
          end else if (is_lw || is_sw) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          mem_we  = is_sw;
          Aluctr  = alu_sel;
          AluSrc  = 1'b1;
          if (mem_ack) begin
            if (is_sw) begin
              retire  = 1'b1;
              state_d = ST_IF;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          RegWr    = 1'b1;
          retire   = 1'b1;
          MemtoReg = is_lw;
          RegDst   = is_r;
          if (is_r) Aluctr = alu_sel;
          state_d  = ST_IF;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IF;
      endcase
    end
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IF;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions with expected latency/retires, random
// instruction stream against a phase-sequence model, plus reset, wrap and halt sequences.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_h = 1'b1;
  logic [5:0]    op = '0;
  logic [5:0]    func = '0;
  logic          zero = 1'b0;
  logic          mem_ack = 1'b0;

  logic          mem_req, mem_we, IorD, IRWr, PCWr, RegWr, RegDst, AluSrc, ExtOp, MemtoReg;
  logic          retire, illegal;
  logic [1:0]    PCSrc;
  logic [2:0]    Aluctr, state;
  logic [CW-1:0] instr_cnt;

  logic          h_mem_req, h_mem_we, h_IorD, h_IRWr, h_PCWr, h_RegWr, h_RegDst, h_AluSrc;
  logic          h_ExtOp, h_MemtoReg, h_retire, h_illegal;
  logic [1:0]    h_PCSrc;
  logic [2:0]    h_Aluctr, h_state;
  logic [15:0]   h_instr_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWr(IRWr), .PCWr(PCWr),
    .PCSrc(PCSrc), .RegWr(RegWr), .RegDst(RegDst), .AluSrc(AluSrc), .ExtOp(ExtOp),
    .MemtoReg(MemtoReg), .Aluctr(Aluctr), .retire(retire), .illegal(illegal),
    .state(state), .instr_cnt(instr_cnt)
  );

  multicycle_ctrl #(.CNT_W(16), .ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst_h), .op(op), .func(func), .zero(zero), .mem_ack(mem_ack),
    .mem_req(h_mem_req), .mem_we(h_mem_we), .IorD(h_IorD), .IRWr(h_IRWr), .PCWr(h_PCWr),
    .PCSrc(h_PCSrc), .RegWr(h_RegWr), .RegDst(h_RegDst), .AluSrc(h_AluSrc), .ExtOp(h_ExtOp),
    .MemtoReg(h_MemtoReg), .Aluctr(h_Aluctr), .retire(h_retire), .illegal(h_illegal),
    .state(h_state), .instr_cnt(h_instr_cnt)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       irwr;
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       regwr;
    logic       regdst;
    logic       alusrc;
    logic       extop;
    logic       memtoreg;
    logic [2:0] aluctr;
    logic       retire;
    logic       illegal;
    logic [2:0] state;
  } outs_t;

  outs_t act, h_act;
  assign act   = {mem_req, mem_we, IorD, IRWr, PCWr, PCSrc, RegWr, RegDst, AluSrc, ExtOp,
                  MemtoReg, Aluctr, retire, illegal, state};
  assign h_act = {h_mem_req, h_mem_we, h_IorD, h_IRWr, h_PCWr, h_PCSrc, h_RegWr, h_RegDst,
                  h_AluSrc, h_ExtOp, h_MemtoReg, h_Aluctr, h_retire, h_illegal, h_state};

  typedef enum int {P_IF, P_ID, P_EX, P_MEM, P_WB} phase_t;
  typedef enum int {K_R, K_ORI, K_ADDIU, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         if_dly;
    int         mem_dly;
    int         exp_cycles;
    int         exp_retire;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cnt_model = 0;

  task automatic check_vec(input string name, input outs_t got, input outs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%05h exp=%05h", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100011 ||
                         f == 6'b101010 || f == 6'b101011) ? K_R : K_ILL;
      6'b001101: return K_ORI;
      6'b001001: return K_ADDIU;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input kind_t k, input logic [5:0] f);
    if (k == K_R) begin
      case (f)
        6'b100000: return 3'b001;
        6'b100010: return 3'b101;
        6'b100011: return 3'b100;
        6'b101010: return 3'b111;
        default:   return 3'b110;
      endcase
    end
    if (k == K_ORI) return 3'b010;
    if (k == K_BEQ) return 3'b100;
    return 3'b000;
  endfunction

  // Expected control word for one cycle of a given instruction in a given phase.
  function automatic outs_t exp_out(input phase_t p, input kind_t k, input logic [5:0] f,
                                    input logic z, input logic ack);
    outs_t o;
    o = '0;
    case (p)
      P_IF: begin
        o.mem_req = 1'b1;
        o.irwr    = ack;
        o.pcwr    = ack;
      end
      P_ID: begin
        o.state = 3'd1;
        if (k == K_J) begin
          o.pcwr = 1'b1; o.pcsrc = 2'b10; o.retire = 1'b1;
        end
        o.illegal = (k == K_ILL);
      end
      P_EX: begin
        o.state  = 3'd2;
        o.aluctr = alu_of(k, f);
        o.regdst = (k == K_R);
        o.alusrc = (k == K_ORI || k == K_ADDIU || k == K_LW || k == K_SW);
        o.extop  = (k == K_ADDIU || k == K_LW || k == K_SW);
        if (k == K_BEQ) begin
          o.pcwr = z; o.pcsrc = 2'b01; o.retire = 1'b1;
        end
      end
      P_MEM: begin
        o.state   = 3'd3;
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
        o.mem_we  = (k == K_SW);
        o.alusrc  = 1'b1;
        o.retire  = ack && (k == K_SW);
      end
      default: begin
        o.state    = 3'd4;
        o.regwr    = 1'b1;
        o.retire   = 1'b1;
        o.memtoreg = (k == K_LW);
        o.regdst   = (k == K_R);
        if (k == K_R) o.aluctr = alu_of(k, f);
      end
    endcase
    return o;
  endfunction

  task automatic one_cycle(input phase_t p, input kind_t k, input logic [5:0] iop,
                           input logic [5:0] ifn, input logic iz, input logic ack,
                           output int nonif, output int ret);
    outs_t e;
    @(negedge clk);
    if (p == P_IF) begin
      op   = 6'($urandom);
      func = 6'($urandom);
    end else begin
      op   = iop;
      func = ifn;
    end
    zero    = (p == P_EX) ? iz : 1'($urandom);
    mem_ack = (p == P_IF || p == P_MEM) ? ack : 1'($urandom);
    #1;
    e = exp_out(p, k, ifn, iz, ack);
    check_vec("ctrl", act, e);
    check_int("instr_cnt", int'(instr_cnt), cnt_model);
    if (e.retire) cnt_model = (cnt_model + 1) % (1 << CW);
    nonif = (act.state != 3'd0) ? 1 : 0;
    ret   = act.retire ? 1 : 0;
  endtask

  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                           input int if_dly, input int mem_dly,
                           output int cycles, output int retires);
    kind_t  k;
    phase_t ph_q[$];
    logic   ak_q[$];
    int     ni, rt;
    k = classify(iop, ifn);
    for (int i = 0; i < if_dly; i++) begin ph_q.push_back(P_IF); ak_q.push_back(1'b0); end
    ph_q.push_back(P_IF); ak_q.push_back(1'b1);
    ph_q.push_back(P_ID); ak_q.push_back(1'b0);
    if (k != K_J && k != K_ILL) begin
      ph_q.push_back(P_EX); ak_q.push_back(1'b0);
      if (k == K_LW || k == K_SW) begin
        for (int i = 0; i < mem_dly; i++) begin ph_q.push_back(P_MEM); ak_q.push_back(1'b0); end
        ph_q.push_back(P_MEM); ak_q.push_back(1'b1);
      end
      if (k != K_BEQ && k != K_SW) begin ph_q.push_back(P_WB); ak_q.push_back(1'b0); end
    end
    cycles  = if_dly + 1;
    retires = 0;
    for (int i = 0; i < ph_q.size(); i++) begin
      one_cycle(ph_q[i], k, iop, ifn, iz, ak_q[i], ni, rt);
      cycles  += ni;
      retires += rt;
    end
    $display("instr op=%b func=%b kind=%s cycles=%0d retires=%0d cnt=%0d",
             iop, ifn, k.name(), cycles, retires, cnt_model);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    check_vec("reset_outs", act, '0);
    check_int("reset_cnt", int'(instr_cnt), 0);
    check_vec("halt_dut_in_reset", h_act, '0);
    @(negedge clk);
    #1;
    check_vec("reset_outs_hold", act, '0);
    mem_ack   = 1'b0;
    rst       = 1'b0;
    cnt_model = 0;
  endtask

  vec_t       tbl[17];
  logic [11:0] pool[16];

  initial begin
    int cyc, ret, ni, rt;
    outs_t he;
    logic [5:0] rop, rfn;

    tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1};
    tbl[1]  = '{6'b000000, 6'b100010, 1'b0, 1, 0, 5, 1};
    tbl[2]  = '{6'b000000, 6'b100011, 1'b1, 0, 0, 4, 1};
    tbl[3]  = '{6'b000000, 6'b101010, 1'b0, 0, 0, 4, 1};
    tbl[4]  = '{6'b000000, 6'b101011, 1'b0, 2, 0, 6, 1};
    tbl[5]  = '{6'b001101, 6'b010101, 1'b0, 0, 0, 4, 1};
    tbl[6]  = '{6'b001001, 6'b000000, 1'b1, 1, 0, 5, 1};
    tbl[7]  = '{6'b100011, 6'b000000, 1'b0, 0, 3, 8, 1};
    tbl[8]  = '{6'b101011, 6'b111111, 1'b0, 0, 0, 4, 1};
    tbl[9]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3, 1};
    tbl[10] = '{6'b000100, 6'b000000, 1'b0, 1, 0, 4, 1};
    tbl[11] = '{6'b000010, 6'b000000, 1'b0, 0, 0, 2, 1};
    tbl[12] = '{6'b111111, 6'b100000, 1'b0, 0, 0, 2, 0};
    tbl[13] = '{6'b000000, 6'b100001, 1'b0, 0, 0, 2, 0};
    tbl[14] = '{6'b100011, 6'b000000, 1'b1, 0, 0, 5, 1};
    tbl[15] = '{6'b101011, 6'b000000, 1'b0, 1, 2, 7, 1};
    tbl[16] = '{6'b000010, 6'b000000, 1'b0, 3, 0, 5, 1};

    pool[0]  = {6'b000000, 6'b100000};
    pool[1]  = {6'b000000, 6'b100010};
    pool[2]  = {6'b000000, 6'b100011};
    pool[3]  = {6'b000000, 6'b101010};
    pool[4]  = {6'b000000, 6'b101011};
    pool[5]  = {6'b001101, 6'b000000};
    pool[6]  = {6'b001001, 6'b000000};
    pool[7]  = {6'b100011, 6'b000000};
    pool[8]  = {6'b101011, 6'b000000};
    pool[9]  = {6'b000100, 6'b000000};
    pool[10] = {6'b000010, 6'b000000};
    pool[11] = {6'b111111, 6'b000000};
    pool[12] = {6'b001000, 6'b000000};
    pool[13] = {6'b000000, 6'b100001};
    pool[14] = {6'b000011, 6'b000000};
    pool[15] = {6'b100011, 6'b000000};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].if_dly, tbl[i].mem_dly, cyc, ret);
      check_int("latency", cyc, tbl[i].exp_cycles);
      check_int("retires", ret, tbl[i].exp_retire);
    end

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 15);
      rop = pool[sel][11:6];
      rfn = (rop == 6'b000000) ? pool[sel][5:0] : 6'($urandom);
      run_instr(rop, rfn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), cyc, ret);
    end

    // Counter wrap: 17 jumps from reset on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, cyc, ret);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_int("wrap_cnt", int'(instr_cnt), 1);

    // Reset pulsed while a store waits in MEM
    one_cycle(P_IF, K_SW, 6'b101011, 6'b000000, 1'b0, 1'b1, ni, rt);
    one_cycle(P_ID, K_SW, 6'b101011, 6'b000000, 1'b0, 1'b0, ni, rt);
    one_cycle(P_EX, K_SW, 6'b101011, 6'b000000, 1'b0, 1'b0, ni, rt);
    one_cycle(P_MEM, K_SW, 6'b101011, 6'b000000, 1'b0, 1'b0, ni, rt);
    do_reset();
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, cyc, ret);
    check_int("after_reset_latency", cyc, 4);

    // ILLEGAL_HALT=1 instance: illegal op parks the FSM
    @(negedge clk);
    rst_h   = 1'b0;
    op      = 6'($urandom);
    mem_ack = 1'b1;
    #1;
    he = '0; he.mem_req = 1'b1; he.irwr = 1'b1; he.pcwr = 1'b1;
    check_vec("halt_if", h_act, he);
    @(negedge clk);
    op      = 6'b111111;
    mem_ack = 1'b0;
    #1;
    he = '0; he.state = 3'd1; he.illegal = 1'b1;
    check_vec("halt_id", h_act, he);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      op      = 6'($urandom);
      mem_ack = 1'($urandom);
      #1;
      he = '0; he.state = 3'd7;
      check_vec("halt_park", h_act, he);
    end
    check_int("halt_cnt", int'(h_instr_cnt), 0);
    $display("halt sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
